// File: rtl/commit_ctrl_pkg.sv
// ============================================================================
// commit_ctrl_pkg : RoB head-type and commit-state encodings shared with RoB/RF
// Revision 1.0
// ============================================================================
`default_nettype none

package commit_ctrl_pkg;

   localparam int ROB_IDX_W_DEF = 4;
   localparam int XLEN_DEF      = 32;

   typedef enum logic [1:0] {
      ROB_T_REG    = 2'd0,
      ROB_T_STORE  = 2'd1,
      ROB_T_BRANCH = 2'd2,
      ROB_T_RSVD   = 2'd3
   } rob_type_e;

   typedef enum logic [1:0] {
      CS_COMMIT     = 2'd0,
      CS_STORE_WAIT = 2'd1,
      CS_FLUSH      = 2'd2,
      CS_CLEAR      = 2'd3
   } commit_state_e;

endpackage

`default_nettype wire

// File: rtl/commit_ctrl_if.sv
// ============================================================================
// commit_ctrl_if : RoB head / register-file / store / redirect bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface commit_ctrl_if #(
   parameter int ROB_IDX_W = commit_ctrl_pkg::ROB_IDX_W_DEF,
   parameter int XLEN      = commit_ctrl_pkg::XLEN_DEF
) ();

   logic                 head_valid;
   logic [ROB_IDX_W-1:0] head_tag;
   logic [1:0]           head_type;
   logic [4:0]           head_rd;
   logic [XLEN-1:0]      head_val;
   logic                 head_mispredict;
   logic [XLEN-1:0]      head_target;
   logic                 head_pop;

   logic [4:0]           rf_set_reg;
   logic [XLEN-1:0]      rf_set_val;
   logic [4:0]           rf_set_reg_q;
   logic [XLEN-1:0]      rf_set_val_q;

   logic                 st_req;
   logic                 st_ack;

   logic                 rob_clear;
   logic                 redirect_valid;
   logic [XLEN-1:0]      redirect_pc;
   logic [31:0]          commit_count;

   modport master (
      input  head_valid, head_tag, head_type, head_rd, head_val,
             head_mispredict, head_target, st_ack,
      output head_pop, rf_set_reg, rf_set_val, rf_set_reg_q, rf_set_val_q,
             st_req, rob_clear, redirect_valid, redirect_pc, commit_count
   );

   modport slave (
      output head_valid, head_tag, head_type, head_rd, head_val,
             head_mispredict, head_target, st_ack,
      input  head_pop, rf_set_reg, rf_set_val, rf_set_reg_q, rf_set_val_q,
             st_req, rob_clear, redirect_valid, redirect_pc, commit_count
   );

endinterface

`default_nettype wire

// File: rtl/commit_ctrl.sv
// ============================================================================
// commit_ctrl : in-order commit sequencer, RoB head -> register file / memory
// Revision 1.0
// ============================================================================
`default_nettype none

module commit_ctrl #(
   parameter int ROB_IDX_W = commit_ctrl_pkg::ROB_IDX_W_DEF,
   parameter int XLEN      = commit_ctrl_pkg::XLEN_DEF
) (
   input  wire logic     clk_in,
   input  wire logic     rst_in,
   input  wire logic     rdy_in,
   commit_ctrl_if.master bus
);

   import commit_ctrl_pkg::*;

   commit_state_e   state_q, state_d;
   logic            st_req_q, st_req_d;
   logic [XLEN-1:0] target_q, target_d;
   logic [4:0]      rf_reg_q, rf_reg_d;
   logic [XLEN-1:0] rf_val_q, rf_val_d;
   logic [4:0]      rel_reg_q, rel_reg_d;
   logic [XLEN-1:0] rel_val_q, rel_val_d;
   logic            clear_q, clear_d;
   logic            redir_valid_q, redir_valid_d;
   logic [XLEN-1:0] redir_pc_q, redir_pc_d;
   logic [31:0]     count_q, count_d;
   logic            pop;

   rob_type_e       htype;
   logic [XLEN-1:0] tag_ext;

   assign htype   = rob_type_e'(bus.head_type);
   assign tag_ext = {{(XLEN-ROB_IDX_W){1'b0}}, bus.head_tag};

   always_comb begin
      state_d       = state_q;
      st_req_d      = st_req_q;
      target_d      = target_q;
      rf_reg_d      = rf_reg_q;
      rf_val_d      = rf_val_q;
      rel_reg_d     = rel_reg_q;
      rel_val_d     = rel_val_q;
      clear_d       = clear_q;
      redir_valid_d = redir_valid_q;
      redir_pc_d    = redir_pc_q;
      count_d       = count_q;
      pop           = 1'b0;

      // rdy_in low freezes everything, including the one-cycle pulses
      if (rdy_in) begin
         rf_reg_d      = '0;
         rf_val_d      = '0;
         rel_reg_d     = '0;
         rel_val_d     = '0;
         clear_d       = 1'b0;
         redir_valid_d = 1'b0;
         redir_pc_d    = '0;

         case (state_q)
            CS_COMMIT: begin
               if (bus.head_valid) begin
                  if (htype == ROB_T_STORE) begin
                     st_req_d = 1'b1;
                     state_d  = CS_STORE_WAIT;
                  end else begin
                     pop       = 1'b1;
                     rf_reg_d  = bus.head_rd;
                     rel_reg_d = bus.head_rd;
                     rf_val_d  = bus.head_val;
                     rel_val_d = tag_ext;
                     if (htype == ROB_T_BRANCH && bus.head_mispredict) begin
                        target_d = bus.head_target;
                        state_d  = CS_FLUSH;
                     end
                  end
               end
            end
            CS_STORE_WAIT: begin
               if (bus.st_ack) begin
                  pop      = 1'b1;
                  st_req_d = 1'b0;
                  state_d  = CS_COMMIT;
               end
            end
            // flush is deferred one cycle so the link write is not dropped by the RF
            CS_FLUSH: begin
               clear_d       = 1'b1;
               redir_valid_d = 1'b1;
               redir_pc_d    = target_q;
               state_d       = CS_CLEAR;
            end
            CS_CLEAR: begin
               state_d = CS_COMMIT;
            end
            default: begin
               state_d = CS_COMMIT;
            end
         endcase

         if (pop) begin
            count_d = count_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q       <= CS_COMMIT;
         st_req_q      <= 1'b0;
         target_q      <= '0;
         rf_reg_q      <= '0;
         rf_val_q      <= '0;
         rel_reg_q     <= '0;
         rel_val_q     <= '0;
         clear_q       <= 1'b0;
         redir_valid_q <= 1'b0;
         redir_pc_q    <= '0;
         count_q       <= '0;
      end else begin
         state_q       <= state_d;
         st_req_q      <= st_req_d;
         target_q      <= target_d;
         rf_reg_q      <= rf_reg_d;
         rf_val_q      <= rf_val_d;
         rel_reg_q     <= rel_reg_d;
         rel_val_q     <= rel_val_d;
         clear_q       <= clear_d;
         redir_valid_q <= redir_valid_d;
         redir_pc_q    <= redir_pc_d;
         count_q       <= count_d;
      end
   end

   assign bus.head_pop       = pop & ~rst_in;
   assign bus.rf_set_reg     = rf_reg_q;
   assign bus.rf_set_val     = rf_val_q;
   assign bus.rf_set_reg_q   = rel_reg_q;
   assign bus.rf_set_val_q   = rel_val_q;
   assign bus.st_req         = st_req_q;
   assign bus.rob_clear      = clear_q;
   assign bus.redirect_valid = redir_valid_q;
   assign bus.redirect_pc    = redir_pc_q;
   assign bus.commit_count   = count_q;

endmodule

`default_nettype wire

// File: tb/tb_commit_ctrl.sv
// ============================================================================
// tb_commit_ctrl : scoreboard bench for commit_ctrl, directed then random
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_commit_ctrl;

   import commit_ctrl_pkg::*;

   localparam int RW = 4;
   localparam int XW = 32;

   logic clk = 1'b0;
   logic rst;
   logic rdy;

   always #5 clk = ~clk;

   commit_ctrl_if #(.ROB_IDX_W(RW), .XLEN(XW)) bus ();

   commit_ctrl #(.ROB_IDX_W(RW), .XLEN(XW)) dut (
      .clk_in (clk),
      .rst_in (rst),
      .rdy_in (rdy),
      .bus    (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      int unsigned due;
      logic [4:0]  rd;
      logic [31:0] val;
      logic [3:0]  tag;
   } rf_exp_t;

   typedef struct {
      int unsigned due;
      logic [31:0] pc;
   } redir_exp_t;

   rf_exp_t    rf_sb[$];
   redir_exp_t rd_sb[$];

   // Reference model: the committer is either free, waiting on a store,
   // or blocked for two active cycles after a mispredicted branch retires.
   bit          m_in_store = 1'b0;
   int          m_blk      = 0;
   logic [31:0] m_count    = '0;
   int unsigned act_no     = 0;
   bit          ed_active  = 1'b0;
   bit          ed_rst     = 1'b0;
   int unsigned ed_act     = 0;
   bit          m_popped   = 1'b0;

   task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   initial begin : model
      bit exp_pop;
      forever begin
         @(negedge clk);
         exp_pop = 1'b0;
         chk("st_req", {63'd0, bus.st_req}, {63'd0, m_in_store});
         chk("commit_count", {32'd0, bus.commit_count}, {32'd0, m_count});
         if (rst) begin
            m_in_store = 1'b0;
            m_blk      = 0;
            m_count    = '0;
            rf_sb.delete();
            rd_sb.delete();
            ed_rst     = 1'b1;
            ed_active  = 1'b0;
         end else begin
            ed_rst = 1'b0;
            if (rdy) begin
               if (m_blk > 0) begin
                  m_blk--;
               end else if (m_in_store) begin
                  if (bus.st_ack) begin
                     exp_pop    = 1'b1;
                     m_in_store = 1'b0;
                  end
               end else if (bus.head_valid) begin
                  if (bus.head_type == ROB_T_STORE) begin
                     m_in_store = 1'b1;
                  end else begin
                     exp_pop = 1'b1;
                     rf_sb.push_back('{act_no, bus.head_rd, bus.head_val, bus.head_tag});
                     if (bus.head_type == ROB_T_BRANCH && bus.head_mispredict) begin
                        m_blk = 2;
                        rd_sb.push_back('{act_no + 1, bus.head_target});
                     end
                  end
               end
               if (exp_pop) m_count = m_count + 32'd1;
               ed_active = 1'b1;
               ed_act    = act_no;
               act_no++;
            end else begin
               ed_active = 1'b0;
            end
         end
         chk("head_pop", {63'd0, bus.head_pop}, {63'd0, exp_pop});
         m_popped = exp_pop;
      end
   end

   // Monitor: examines the registered outputs after every edge that loaded them.
   rf_exp_t     mon_rf;
   bit          mon_w;
   bit          mon_r;
   logic [31:0] mon_pc;

   initial begin : monitor
      forever begin
         @(posedge clk);
         #2;
         if (ed_rst || ed_active) begin
            mon_rf = '{0, 5'd0, 32'd0, 4'd0};
            mon_w  = 1'b0;
            mon_r  = 1'b0;
            mon_pc = '0;
            if (ed_active) begin
               while (rf_sb.size() > 0 && rf_sb[0].due < ed_act) void'(rf_sb.pop_front());
               while (rd_sb.size() > 0 && rd_sb[0].due < ed_act) void'(rd_sb.pop_front());
               if (rf_sb.size() > 0 && rf_sb[0].due == ed_act) begin
                  mon_rf = rf_sb.pop_front();
                  mon_w  = 1'b1;
               end
               if (rd_sb.size() > 0 && rd_sb[0].due == ed_act) begin
                  mon_pc = rd_sb.pop_front().pc;
                  mon_r  = 1'b1;
               end
            end
            chk("rf_set_reg", {59'd0, bus.rf_set_reg}, {59'd0, mon_rf.rd});
            chk("rf_set_reg_q", {59'd0, bus.rf_set_reg_q}, {59'd0, mon_rf.rd});
            // with rd=0 the value fields carry no meaning
            if (!mon_w || mon_rf.rd != 5'd0) begin
               chk("rf_set_val", {32'd0, bus.rf_set_val}, {32'd0, mon_rf.val});
               chk("rf_set_val_q", {32'd0, bus.rf_set_val_q}, {60'd0, mon_rf.tag});
            end
            chk("rob_clear", {63'd0, bus.rob_clear}, {63'd0, mon_r});
            chk("redirect_valid", {63'd0, bus.redirect_valid}, {63'd0, mon_r});
            chk("redirect_pc", {32'd0, bus.redirect_pc}, {32'd0, mon_pc});
         end
      end
   end

   task automatic drive(bit r, bit y, bit hv, logic [1:0] ty, logic [4:0] rd,
                        logic [31:0] v, logic [3:0] tg, bit mis, logic [31:0] tgt, bit ack);
      @(posedge clk);
      #1;
      rst                 = r;
      rdy                 = y;
      bus.head_valid      = hv;
      bus.head_type       = ty;
      bus.head_rd         = rd;
      bus.head_val        = v;
      bus.head_tag        = tg;
      bus.head_mispredict = mis;
      bus.head_target     = tgt;
      bus.st_ack          = ack;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) drive(0, 1, 0, ROB_T_REG, 5'd0, 32'd0, 4'd0, 0, 32'd0, 0);
   endtask

   initial begin : stimulus
      logic [1:0]  h_ty;
      logic [4:0]  h_rd;
      logic [31:0] h_val;
      logic [3:0]  h_tag;
      bit          h_mis;
      logic [31:0] h_tgt;
      bit          prev_ack;

      rst = 1'b1;
      rdy = 1'b1;
      bus.head_valid      = 1'b0;
      bus.head_type       = ROB_T_REG;
      bus.head_rd         = '0;
      bus.head_val        = '0;
      bus.head_tag        = '0;
      bus.head_mispredict = 1'b0;
      bus.head_target     = '0;
      bus.st_ack          = 1'b0;
      drive(1, 1, 0, ROB_T_REG, 5'd0, 32'd0, 4'd0, 0, 32'd0, 0);
      idle(2);

      drive(0, 1, 1, ROB_T_REG, 5'd5, 32'hDEADBEEF, 4'd3, 0, 32'd0, 0);
      idle(1);
      drive(0, 1, 1, ROB_T_REG, 5'd0, 32'h0000_1234, 4'd2, 0, 32'd0, 0);
      idle(1);

      drive(0, 1, 1, ROB_T_STORE, 5'd0, 32'h55, 4'd4, 0, 32'd0, 0);
      for (int i = 0; i < 3; i++) drive(0, 1, 1, ROB_T_STORE, 5'd0, 32'h55, 4'd4, 0, 32'd0, 0);
      drive(0, 1, 1, ROB_T_STORE, 5'd0, 32'h55, 4'd4, 0, 32'd0, 1);
      idle(1);

      drive(0, 1, 1, ROB_T_BRANCH, 5'd1, 32'h104, 4'd6, 1, 32'h200, 0);
      idle(3);

      drive(0, 1, 1, ROB_T_STORE, 5'd0, 32'h66, 4'd7, 0, 32'd0, 0);
      drive(0, 1, 1, ROB_T_REG, 5'd9, 32'h99, 4'd8, 0, 32'd0, 0);
      for (int i = 0; i < 3; i++) drive(0, 0, 1, ROB_T_REG, 5'd9, 32'h99, 4'd8, 0, 32'd0, 0);
      drive(0, 1, 1, ROB_T_REG, 5'd9, 32'h99, 4'd8, 0, 32'd0, 1);
      idle(1);

      drive(0, 1, 1, ROB_T_STORE, 5'd0, 32'h77, 4'd9, 0, 32'd0, 0);
      idle(2);
      drive(1, 1, 1, ROB_T_REG, 5'd3, 32'h33, 4'd1, 0, 32'd0, 0);
      for (int i = 0; i < 4; i++)
         drive(0, 1, 1, ROB_T_REG, 5'(i + 2), 32'h1000 + 32'(i), 4'(i + 10), 0, 32'd0, 0);

      drive(0, 1, 1, ROB_T_BRANCH, 5'd0, 32'h500, 4'd2, 1, 32'h8000_0040, 0);
      drive(0, 1, 1, ROB_T_RSVD, 5'd31, 32'hCAFE_F00D, 4'd15, 1, 32'h1, 0);
      drive(0, 1, 1, ROB_T_BRANCH, 5'd12, 32'h44, 4'd5, 0, 32'hFFFF_FFFC, 0);
      drive(0, 1, 1, ROB_T_RSVD, 5'd31, 32'hCAFE_F00D, 4'd15, 1, 32'h1, 0);
      idle(3);

      h_ty = 2'($urandom_range(0, 3)); h_rd = 5'($urandom); h_val = $urandom;
      h_tag = 4'($urandom); h_mis = 1'($urandom); h_tgt = $urandom;
      prev_ack = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         bit ack;
         @(posedge clk);
         #1;
         if (m_popped) begin
            h_ty  = 2'($urandom_range(0, 3));
            h_rd  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            h_val = $urandom;
            h_tag = 4'($urandom);
            h_mis = 1'($urandom);
            h_tgt = $urandom;
         end
         ack = bus.st_req && !prev_ack && ($urandom_range(0, 3) == 0);
         prev_ack            = ack;
         rst                 = ($urandom_range(0, 199) == 0);
         rdy                 = ($urandom_range(0, 6) != 0);
         bus.head_valid      = ($urandom_range(0, 9) < 7);
         bus.head_type       = h_ty;
         bus.head_rd         = h_rd;
         bus.head_val        = h_val;
         bus.head_tag        = h_tag;
         bus.head_mispredict = h_mis;
         bus.head_target     = h_tgt;
         bus.st_ack          = ack;
      end

      idle(4);
      @(negedge clk);
      chk("rf_sb_drained", 64'(rf_sb.size()), 64'd0);
      chk("redir_sb_drained", 64'(rd_sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
